// File: rtl/tick_sched_pkg.sv
// Shared state encoding and default divider constants for the Bricks time base.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    STEP  = 2'd3
  } state_t;

  localparam int CNT_W         = 32;
  localparam int SCAN_DIV_DEF  = 5000;
  localparam int GAME_DIV_DEF  = 500000;
  localparam int GAME_STEP_DEF = 50000;
  localparam int GAME_MIN_DEF  = 100000;
  localparam int BLINK_DIV_DEF = 12500000;

endpackage

// File: rtl/strobe_divider.sv
// Programmable wrap counter: counts 0..period-1 and registers a one-cycle wrap
// strobe, or with TOGGLE set, a level that flips on every wrap.
module strobe_divider #(
  parameter int CNT_W  = 32,
  parameter bit TOGGLE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign hit = enable && (cnt == period - ONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      wrap <= TOGGLE ? wrap : 1'b0;
    end else begin
      if (hit)
        cnt <= '0;
      else if (enable)
        cnt <= cnt + ONE;
      wrap <= TOGGLE ? (wrap ^ hit) : hit;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Bricks time base: scan/game strobes, UI blink and the run/pause/step sequencer.
// Define TICK_SPEEDUP_EN to make the game period follow speed_level.
//
// state | meaning
// IDLE  | game counter held at 0, waiting for run_req
// RUN   | game counter advancing, ticks at the latched period
// PAUSE | game counter frozen, run_req resumes, step_req steps
// STEP  | one-cycle visit that emits a single game tick
module tick_scheduler #(
  parameter int SCAN_DIV  = tick_sched_pkg::SCAN_DIV_DEF,
  parameter int GAME_DIV  = tick_sched_pkg::GAME_DIV_DEF,
  parameter int GAME_STEP = tick_sched_pkg::GAME_STEP_DEF,
  parameter int GAME_MIN  = tick_sched_pkg::GAME_MIN_DEF,
  parameter int BLINK_DIV = tick_sched_pkg::BLINK_DIV_DEF,
  parameter int CNT_W     = tick_sched_pkg::CNT_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run_req,
  input  logic        pause_req,
  input  logic        step_req,
  input  logic        stop_req,
  input  logic [2:0]  speed_level,
  output logic        scan_tick,
  output logic        game_tick,
  output logic        blink,
  output logic [1:0]  state,
  output logic [15:0] tick_count
);

  import tick_sched_pkg::*;

  localparam logic [CNT_W-1:0] SCAN_P  = CNT_W'(SCAN_DIV);
  localparam logic [CNT_W-1:0] BLINK_P = CNT_W'(BLINK_DIV);
  localparam logic [CNT_W-1:0] GAME_P  = CNT_W'(GAME_DIV);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_sel;
  logic             game_wrap, step_q, game_clear, game_en, latch_period;

`ifdef TICK_SPEEDUP_EN
  localparam logic [CNT_W-1:0] HEADROOM =
    (GAME_DIV > GAME_MIN) ? CNT_W'(GAME_DIV - GAME_MIN) : '0;

  logic [CNT_W-1:0] reduction;

  // Clamp test happens before the subtraction so the period never underflows.
  assign reduction  = CNT_W'(speed_level) * CNT_W'(GAME_STEP);
  assign period_sel = (reduction > HEADROOM) ? CNT_W'(GAME_MIN) : (GAME_P - reduction);
`else
  logic [CNT_W-1:0] cfg_unused;

  assign cfg_unused = CNT_W'(GAME_STEP) ^ CNT_W'(GAME_MIN) ^ CNT_W'(speed_level);
  assign period_sel = GAME_P;
`endif

  always_comb begin
    state_d = state_q;
    if (stop_req) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (run_req) state_d = RUN;
        RUN:     if (pause_req) state_d = PAUSE;
        PAUSE:   if (run_req) state_d = RUN;
                 else if (step_req) state_d = STEP;
        STEP:    state_d = PAUSE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign game_en      = (state_q == RUN);
  assign game_clear   = stop_req || (state_q == IDLE);
  // The wrap strobe is visible while the counter reads 0, so the new period
  // is in place before the next terminal-count compare can matter.
  assign latch_period = game_wrap || ((state_q == IDLE) && (state_d == RUN));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      step_q     <= 1'b0;
      period_q   <= '0;
      tick_count <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= (state_d == STEP);
      if (latch_period)
        period_q <= period_sel;
      if (stop_req)
        tick_count <= '0;
      else if (game_tick)
        tick_count <= tick_count + 16'd1;
    end
  end

  assign game_tick = game_wrap | step_q;
  assign state     = state_q;

  strobe_divider #(.CNT_W(CNT_W), .TOGGLE(1'b0)) u_scan (
    .clock  (clock),
    .reset  (reset),
    .enable (1'b1),
    .clear  (1'b0),
    .period (SCAN_P),
    .wrap   (scan_tick)
  );

  strobe_divider #(.CNT_W(CNT_W), .TOGGLE(1'b1)) u_blink (
    .clock  (clock),
    .reset  (reset),
    .enable (1'b1),
    .clear  (1'b0),
    .period (BLINK_P),
    .wrap   (blink)
  );

  strobe_divider #(.CNT_W(CNT_W), .TOGGLE(1'b0)) u_game (
    .clock  (clock),
    .reset  (reset),
    .enable (game_en),
    .clear  (game_clear),
    .period (period_q),
    .wrap   (game_wrap)
  );

endmodule
